// File: rtl/octane_filter_pkg.sv
// Shared types and constants for the filter-history sequencer.
package octane_filter_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned NUM_BANKS  = 3;

  // Bank indices: x[n], x[n-1], x[n-2]
  localparam int unsigned BANK_N  = 0;
  localparam int unsigned BANK_N1 = 1;
  localparam int unsigned BANK_N2 = 2;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CLEAR = 2'd3
  } seq_state_t;

endpackage

// File: rtl/filter_delay_line.sv
// Fixed-depth shift register with synchronous clear; used to align addresses and read data.
module filter_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic [WIDTH-1:0] i_Data,
  output logic [WIDTH-1:0] o_Data
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per cycle; reset flushes every stage
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= i_Data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign o_Data = stage_q[DEPTH-1];

endmodule

// File: rtl/filter_history_sequencer.sv
// Sweeps the three-bank filter history: reads each entry, then writes back the shifted history
// once the filter result is available. Also zero-flushes all banks on request.
module filter_history_sequencer #(
  parameter int unsigned NUM_ENTRIES    = 256,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned FILTER_LATENCY = 3
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic                    i_SampleStart,
  input  logic                    i_Clear,
  output logic [3*ADDR_WIDTH-1:0] o_ReadAddress,
  output logic                    o_ReadValid,
  input  logic [3*DATA_WIDTH-1:0] i_FilterDataOut,
  input  logic [DATA_WIDTH-1:0]   i_NewSample,
  output logic [ADDR_WIDTH-1:0]   o_WriteAddress,
  output logic [2:0]              o_WriteEnable,
  output logic [3*DATA_WIDTH-1:0] o_WriteData,
  output logic                    o_Busy,
  output logic                    o_Done,
  output logic                    o_Overrun
);

  import octane_filter_pkg::seq_state_t;
  import octane_filter_pkg::ST_IDLE;
  import octane_filter_pkg::ST_SWEEP;
  import octane_filter_pkg::ST_DRAIN;
  import octane_filter_pkg::ST_CLEAR;
  import octane_filter_pkg::BANK_N;
  import octane_filter_pkg::BANK_N1;
  import octane_filter_pkg::BANK_N2;

  localparam int unsigned WRITE_DELAY = READ_LATENCY + FILTER_LATENCY;
  localparam int unsigned PIPE_WIDTH  = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ENTRIES - 1);

  // Elaboration-time sanity on the geometry
  if (NUM_ENTRIES <= WRITE_DELAY) begin : g_bad_depth
    $error("filter_history_sequencer: NUM_ENTRIES must exceed READ_LATENCY + FILTER_LATENCY");
  end
  if ((64'd1 << ADDR_WIDTH) < 64'(NUM_ENTRIES)) begin : g_bad_addr
    $error("filter_history_sequencer: ADDR_WIDTH too narrow for NUM_ENTRIES");
  end
  if (FILTER_LATENCY < 1) begin : g_bad_filt
    $error("filter_history_sequencer: FILTER_LATENCY must be at least 1");
  end

  seq_state_t            state_q;
  seq_state_t            state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  done_q;
  logic                  overrun_q;

  logic                  accept_c;
  logic                  request_c;
  logic                  addr_last_c;
  logic                  rd_valid_c;
  logic [PIPE_WIDTH-1:0] wb_pipe_in_c;
  logic [PIPE_WIDTH-1:0] wb_pipe_out;
  logic                  wb_valid_c;
  logic [ADDR_WIDTH-1:0] wb_addr_c;
  logic                  wb_last_c;
  logic [DATA_WIDTH-1:0] rd_n_dly;
  logic [DATA_WIDTH-1:0] rd_n1_dly;
  logic                  unused_bank2_rd;

  assign request_c    = i_SampleStart | i_Clear;
  assign accept_c     = (state_q == ST_IDLE) && request_c;
  assign addr_last_c  = (addr_q == LAST_ADDR);
  assign rd_valid_c   = (state_q == ST_SWEEP);
  assign wb_pipe_in_c = {rd_valid_c, rd_valid_c ? addr_q : ADDR_WIDTH'(0)};
  assign wb_valid_c   = wb_pipe_out[ADDR_WIDTH];
  assign wb_addr_c    = wb_pipe_out[ADDR_WIDTH-1:0];
  assign wb_last_c    = wb_valid_c && (wb_addr_c == LAST_ADDR);

  // The x[n-2] bank is overwritten, never forwarded
  assign unused_bank2_rd = ^i_FilterDataOut[BANK_N2*DATA_WIDTH +: DATA_WIDTH];

  // Read address/valid delayed to the write-back slot
  filter_delay_line #(
    .DEPTH (WRITE_DELAY),
    .WIDTH (PIPE_WIDTH)
  ) u_wb_pipe (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Data  (wb_pipe_in_c),
    .o_Data  (wb_pipe_out)
  );

  // x[n] read data aligned with the filter result
  filter_delay_line #(
    .DEPTH (FILTER_LATENCY),
    .WIDTH (DATA_WIDTH)
  ) u_bank_n_pipe (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Data  (i_FilterDataOut[BANK_N*DATA_WIDTH +: DATA_WIDTH]),
    .o_Data  (rd_n_dly)
  );

  // x[n-1] read data aligned with the filter result
  filter_delay_line #(
    .DEPTH (FILTER_LATENCY),
    .WIDTH (DATA_WIDTH)
  ) u_bank_n1_pipe (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Data  (i_FilterDataOut[BANK_N1*DATA_WIDTH +: DATA_WIDTH]),
    .o_Data  (rd_n1_dly)
  );

  // State register
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; clear has priority over start
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Clear) begin
          state_d = ST_CLEAR;
        end else if (i_SampleStart) begin
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (addr_last_c) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wb_last_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (addr_last_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address counter, completion and overrun flags
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      addr_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (accept_c) begin
        addr_q <= '0;
      end else if (((state_q == ST_SWEEP) || (state_q == ST_CLEAR)) && !addr_last_c) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
      done_q    <= ((state_q == ST_DRAIN) && wb_last_c) ||
                   ((state_q == ST_CLEAR) && addr_last_c);
      overrun_q <= (state_q != ST_IDLE) && request_c;
    end
  end

  // Output decode: reads during sweep, write-back from the pipe, or zero writes during clear
  always_comb begin
    o_ReadAddress  = '0;
    o_ReadValid    = 1'b0;
    o_WriteAddress = '0;
    o_WriteEnable  = 3'b000;
    o_WriteData    = '0;
    o_Busy         = (state_q != ST_IDLE);
    o_Done         = done_q;
    o_Overrun      = overrun_q;
    if (rd_valid_c) begin
      o_ReadValid   = 1'b1;
      o_ReadAddress = {3{addr_q}};
    end
    if (state_q == ST_CLEAR) begin
      o_WriteAddress = addr_q;
      o_WriteEnable  = 3'b111;
    end else if (wb_valid_c) begin
      o_WriteAddress = wb_addr_c;
      o_WriteEnable  = 3'b111;
      o_WriteData[BANK_N*DATA_WIDTH  +: DATA_WIDTH] = i_NewSample;
      o_WriteData[BANK_N1*DATA_WIDTH +: DATA_WIDTH] = rd_n_dly;
      o_WriteData[BANK_N2*DATA_WIDTH +: DATA_WIDTH] = rd_n1_dly;
    end
  end

endmodule

// File: tb/tb_filter_history_sequencer.sv
// Bench for filter_history_sequencer: register-file model plus write-back scoreboard.
module tb_filter_history_sequencer;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  typedef struct {
    int          cyc;
    int          addr;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
  } wexp_t;

  logic          clk = 1'b0;
  logic          i_Reset;
  logic          i_SampleStart;
  logic          i_Clear;
  logic [3*AW-1:0] o_ReadAddress;
  logic          o_ReadValid;
  logic [3*DW-1:0] i_FilterDataOut = '0;
  logic [DW-1:0] i_NewSample;
  logic [AW-1:0] o_WriteAddress;
  logic [2:0]    o_WriteEnable;
  logic [3*DW-1:0] o_WriteData;
  logic          o_Busy;
  logic          o_Done;
  logic          o_Overrun;

  int          cyc = 0;
  int          sample_base = 0;
  int          load_pat = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] b0 [256];
  logic [15:0] b1 [256];
  logic [15:0] b2 [256];
  wexp_t       sb [$];

  always #5 clk = ~clk;

  assign i_NewSample = 16'(sample_base + int'(o_WriteAddress));

  filter_history_sequencer #(
    .NUM_ENTRIES    (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .READ_LATENCY   (1),
    .FILTER_LATENCY (3)
  ) dut (
    .i_Clock         (clk),
    .i_Reset         (i_Reset),
    .i_SampleStart   (i_SampleStart),
    .i_Clear         (i_Clear),
    .o_ReadAddress   (o_ReadAddress),
    .o_ReadValid     (o_ReadValid),
    .i_FilterDataOut (i_FilterDataOut),
    .i_NewSample     (i_NewSample),
    .o_WriteAddress  (o_WriteAddress),
    .o_WriteEnable   (o_WriteEnable),
    .o_WriteData     (o_WriteData),
    .o_Busy          (o_Busy),
    .o_Done          (o_Done),
    .o_Overrun       (o_Overrun)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Register file model: one-cycle read latency, per-bank writes, bench preloads
  always @(posedge clk) begin
    cyc <= cyc + 1;
    i_FilterDataOut <= {b2[o_ReadAddress[2*AW +: AW]], b1[o_ReadAddress[AW +: AW]],
                        b0[o_ReadAddress[0 +: AW]]};
    if (load_pat == 1) begin
      for (int a = 0; a < 256; a++) begin
        b0[a] = 16'(a);
        b1[a] = 16'(100 + a);
        b2[a] = 16'h0055;
      end
    end else if (load_pat == 2) begin
      for (int a = 0; a < 256; a++) begin
        b0[a] = 16'h7FFF;
        b1[a] = 16'h7FFF;
        b2[a] = 16'h7FFF;
      end
    end
    if (o_WriteEnable[0] === 1'b1) b0[o_WriteAddress] = o_WriteData[0 +: DW];
    if (o_WriteEnable[1] === 1'b1) b1[o_WriteAddress] = o_WriteData[DW +: DW];
    if (o_WriteEnable[2] === 1'b1) b2[o_WriteAddress] = o_WriteData[2*DW +: DW];
  end

  // Monitor: reads push expected write-backs, writes pop and compare
  always @(negedge clk) begin
    wexp_t e;
    int    ra;
    if (o_Done === 1'b1) done_cnt++;
    if (o_WriteEnable !== 3'b000 && !$isunknown(o_WriteEnable)) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = sb.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_addr", o_WriteAddress, e.addr);
        check("wr_en", o_WriteEnable, 3'b111);
        check("wr_d0", o_WriteData[0 +: DW], e.d0);
        check("wr_d1", o_WriteData[DW +: DW], e.d1);
        check("wr_d2", o_WriteData[2*DW +: DW], e.d2);
      end
    end
    if (o_ReadValid === 1'b1) begin
      rd_cnt++;
      ra = int'(o_ReadAddress[0 +: AW]);
      sb.push_back('{cyc + 4, ra, 16'(sample_base + ra), b0[ra], b1[ra]});
    end
  end

  task automatic load(input int pat);
    load_pat = pat;
    @(posedge clk); #1;
    load_pat = 0;
  endtask

  // Launch an operation; optionally poke start at cycle poke_at; return at the o_Done cycle
  task automatic run_op(input bit clr, input bit st, input int base, input int poke_at,
                        output int done_t, output int busy_n, output int ovr_t, output int ovr_n);
    int c0;
    int t;
    sample_base = base;
    c0 = cyc;
    done_t = -1; busy_n = 0; ovr_t = -1; ovr_n = 0;
    i_Clear = clr;
    i_SampleStart = st;
    if (clr) for (int i = 0; i < int'(N); i++) sb.push_back('{c0 + 1 + i, i, 16'd0, 16'd0, 16'd0});
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      t = cyc - c0;
      i_Clear = 1'b0;
      i_SampleStart = (t == poke_at);
      if (o_Busy) busy_n++;
      if (o_Overrun) begin ovr_n++; ovr_t = t; end
      if (o_Done) begin done_t = t; break; end
    end
    i_SampleStart = 1'b0;
    if (done_t < 0) check("op_done_timeout", 0, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_addr"}, o_ReadAddress, 0);
    check({tag, "_rd_valid"}, o_ReadValid, 0);
    check({tag, "_wr_addr"}, o_WriteAddress, 0);
    check({tag, "_wr_en"}, o_WriteEnable, 0);
    check({tag, "_wr_data"}, o_WriteData, 0);
    check({tag, "_busy"}, o_Busy, 0);
    check({tag, "_done"}, o_Done, 0);
    check({tag, "_overrun"}, o_Overrun, 0);
  endtask

  initial begin
    int          done_t, busy_n, ovr_t, ovr_n, r0, d0, c0;
    logic [15:0] s0 [N];
    logic [15:0] s1 [N];

    i_Reset = 1'b1; i_SampleStart = 1'b0; i_Clear = 1'b0;
    sample_base = 123;
    repeat (3) @(posedge clk);
    #1 i_Reset = 1'b0;
    repeat (10) @(posedge clk);
    #1 check_idle_outputs("reset_idle");

    // Sweep 1: bank0=a, bank1=100+a
    load(1);
    r0 = rd_cnt;
    run_op(0, 1, 200, -1, done_t, busy_n, ovr_t, ovr_n);
    check("sw1_done_cycle", done_t, 13);
    check("sw1_busy_cycles", busy_n, 12);
    check("sw1_busy_at_done", o_Busy, 0);
    check("sw1_reads", rd_cnt - r0, N);
    check("sw1_sb_empty", sb.size(), 0);
    for (int a = 0; a < int'(N); a++) begin
      check("sw1_b0", b0[a], 200 + a);
      check("sw1_b1", b1[a], a);
      check("sw1_b2", b2[a], 100 + a);
    end

    // Sweep 2 launched in the o_Done cycle of sweep 1
    run_op(0, 1, 300, -1, done_t, busy_n, ovr_t, ovr_n);
    check("sw2_done_cycle", done_t, 13);
    check("sw2_overrun", ovr_n, 0);
    for (int a = 0; a < int'(N); a++) begin
      check("sw2_b0", b0[a], 300 + a);
      check("sw2_b1", b1[a], 200 + a);
      check("sw2_b2", b2[a], a);
    end

    // Clear over a full-scale history
    load(2);
    r0 = rd_cnt;
    run_op(1, 0, 77, -1, done_t, busy_n, ovr_t, ovr_n);
    check("clr_done_cycle", done_t, 9);
    check("clr_busy_cycles", busy_n, 8);
    check("clr_reads", rd_cnt - r0, 0);
    check("clr_sb_empty", sb.size(), 0);
    for (int a = 0; a < int'(N); a++) check("clr_banks", {b2[a], b1[a], b0[a]}, 0);

    // Start poked mid-sweep: overrun pulse only
    load(1);
    d0 = done_cnt;
    run_op(0, 1, 200, 3, done_t, busy_n, ovr_t, ovr_n);
    check("ovr_count", ovr_n, 1);
    check("ovr_cycle", ovr_t, 4);
    check("ovr_done_cycle", done_t, 13);
    repeat (8) @(posedge clk);
    #1;
    check("ovr_single_done", done_cnt - d0, 1);
    check("ovr_busy_after", o_Busy, 0);
    for (int a = 0; a < int'(N); a++) begin
      check("ovr_b0", b0[a], 200 + a);
      check("ovr_b1", b1[a], a);
      check("ovr_b2", b2[a], 100 + a);
    end

    // Clear and start together from idle
    r0 = rd_cnt;
    run_op(1, 1, 55, -1, done_t, busy_n, ovr_t, ovr_n);
    check("both_done_cycle", done_t, 9);
    check("both_overrun", ovr_n, 0);
    check("both_reads", rd_cnt - r0, 0);
    for (int a = 0; a < int'(N); a++) check("both_banks", {b2[a], b1[a], b0[a]}, 0);

    // Reset at sweep cycle 5
    load(1);
    sample_base = 500;
    c0 = cyc;
    d0 = done_cnt;
    i_SampleStart = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      i_SampleStart = 1'b0;
      if (cyc - c0 == 5) i_Reset = 1'b1;
    end
    i_Reset = 1'b0;
    sb.delete();
    check("rst_mid_cycle", cyc - c0, 6);
    check_idle_outputs("rst_mid");
    r0 = wr_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("rst_no_writes", wr_cnt - r0, 0);
    check("rst_no_done", done_cnt - d0, 0);
    for (int a = 0; a < int'(N); a++) begin
      s0[a] = b0[a];
      s1[a] = b1[a];
    end
    run_op(0, 1, 400, -1, done_t, busy_n, ovr_t, ovr_n);
    check("post_rst_done_cycle", done_t, 13);
    check("post_rst_busy_cycles", busy_n, 12);
    for (int a = 0; a < int'(N); a++) begin
      check("post_rst_b0", b0[a], 400 + a);
      check("post_rst_b1", b1[a], s0[a]);
      check("post_rst_b2", b2[a], s1[a]);
    end
    check("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
